// File: rtl/window_max_stream.sv
// Streaming signed max-pool reducer: one window of K*K elements in, one maximum out.
// Latency: out_valid rises two cycles after the last beat of a window is accepted.
// Backpressure: in_ready drops from the last beat until the result is taken via out_ready.
module window_max_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 9,
  parameter int KMAX       = 13
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [1:0]                    ksize,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*DATA_WIDTH-1:0]   in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         max_out,
  output logic                          busy
);

  localparam int NMAX = KMAX * KMAX;
  localparam int CW   = $clog2(NMAX + 1);
  localparam int TW   = $clog2(LANES + 1);
  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  function automatic int beats_of(input int n);
    return (n + LANES - 1) / LANES;
  endfunction

  function automatic int tail_of(input int n);
    return n - (beats_of(n) - 1) * LANES;
  endfunction

  // Window geometry for the four supported kernels (1x1, 5x5, 9x9, 13x13)
  localparam int LAST1  = beats_of(1) - 1;
  localparam int LAST5  = beats_of(25) - 1;
  localparam int LAST9  = beats_of(81) - 1;
  localparam int LAST13 = beats_of(169) - 1;
  localparam int TAIL1  = tail_of(1);
  localparam int TAIL5  = tail_of(25);
  localparam int TAIL9  = tail_of(81);
  localparam int TAIL13 = tail_of(169);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_OUT} state_t;

  state_t                 state_q, state_d;
  logic [1:0]             k_q, k_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  tree_q, tree_d;
  logic                   tree_vld_q, tree_vld_d;
  logic [DATA_WIDTH-1:0]  acc_q, acc_d;
  logic [DATA_WIDTH-1:0]  max_q, max_d;
  logic                   rdy_en_q;

  logic [1:0]             k_eff;
  logic [CW-1:0]          last_cnt;
  logic [TW-1:0]          tail_lanes;
  logic                   is_last;
  logic                   accept;
  logic [DATA_WIDTH-1:0]  lane_v;
  logic [DATA_WIDTH-1:0]  tree_max;
  logic [DATA_WIDTH-1:0]  fold;

  // Kernel in force: live ksize on the opening beat, latched copy afterwards
  always_comb begin
    k_eff      = (state_q == S_IDLE) ? ksize : k_q;
    last_cnt   = CW'(LAST1);
    tail_lanes = TW'(TAIL1);
    case (k_eff)
      2'b00: begin last_cnt = CW'(LAST1);  tail_lanes = TW'(TAIL1);  end
      2'b01: begin last_cnt = CW'(LAST5);  tail_lanes = TW'(TAIL5);  end
      2'b10: begin last_cnt = CW'(LAST9);  tail_lanes = TW'(TAIL9);  end
      default: begin last_cnt = CW'(LAST13); tail_lanes = TW'(TAIL13); end
    endcase
  end

  assign is_last = (cnt_q == last_cnt);
  assign accept  = in_valid && in_ready;

  // Lane reduction; lanes past the window end on the final beat count as most-negative
  always_comb begin
    tree_max = MOST_NEG;
    lane_v   = MOST_NEG;
    for (int i = 0; i < LANES; i++) begin
      lane_v = in_data[(LANES-1-i)*DATA_WIDTH +: DATA_WIDTH];
      if (is_last && (i >= int'(tail_lanes))) lane_v = MOST_NEG;
      if ($signed(lane_v) > $signed(tree_max)) tree_max = lane_v;
    end
  end

  assign fold = (tree_vld_q && ($signed(tree_q) > $signed(acc_q))) ? tree_q : acc_q;

  // Next-state: beat acceptance, drain fold and result hand-off
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    cnt_d      = cnt_q;
    tree_d     = tree_q;
    tree_vld_d = 1'b0;
    acc_d      = fold;
    max_d      = max_q;
    case (state_q)
      S_IDLE, S_ACCUM: begin
        if (accept) begin
          tree_d     = tree_max;
          tree_vld_d = 1'b1;
          if (state_q == S_IDLE) k_d = ksize;
          if (is_last) begin
            cnt_d   = '0;
            state_d = S_DRAIN;
          end else begin
            cnt_d   = cnt_q + CW'(1);
            state_d = S_ACCUM;
          end
        end
      end
      S_DRAIN: begin
        max_d   = fold;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          acc_d   = MOST_NEG;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      k_q        <= 2'b00;
      cnt_q      <= '0;
      tree_q     <= MOST_NEG;
      tree_vld_q <= 1'b0;
      acc_q      <= MOST_NEG;
      max_q      <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      cnt_q      <= cnt_d;
      tree_q     <= tree_d;
      tree_vld_q <= tree_vld_d;
      acc_q      <= acc_d;
      max_q      <= max_d;
    end
  end

  // Hold in_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_en_q <= 1'b0;
    else        rdy_en_q <= 1'b1;
  end

  assign in_ready  = rdy_en_q && ((state_q == S_IDLE) || (state_q == S_ACCUM));
  assign out_valid = (state_q == S_OUT);
  assign busy      = (state_q != S_IDLE);
  assign max_out   = max_q;

endmodule
